// File: rtl/letc_core_pkg.sv
// rtl/letc_core_pkg.sv - shared types for the LETC core M1 (memory 1) stage
//
// Purpose: stage payload structs, memory op/size enums, the M1 request FSM
// state enum, and flattened widths so stage ports can stay plain vectors.
package letc_core_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2,
    MEM_OP_AMO   = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    RD_SRC_ALU = 2'd0,
    RD_SRC_MEM = 2'd1,
    RD_SRC_CSR = 2'd2,
    RD_SRC_PC4 = 2'd3
  } rd_src_e;

  typedef enum logic [1:0] {
    M1_IDLE = 2'd0,
    M1_REQ  = 2'd1,
    M1_SENT = 2'd2
  } m1_req_state_e;

  typedef struct packed {
    word_t      pc;
    rd_src_e    rd_src;
    logic [4:0] rd_idx;
    logic       rd_we;
    logic [2:0] csr_op;
    logic [11:0] csr_idx;
    word_t      alu_result;
    logic [4:0] rs2_idx;
    word_t      rs2_val;
    mem_op_e    mem_op;
    logic       mem_signed;
    mem_size_e  mem_size;
    logic [4:0] amo_alu_op;
    logic       branch_taken;
    word_t      branch_target;
  } e_to_m1_s;

  typedef struct packed {
    word_t      pc;
    rd_src_e    rd_src;
    logic [4:0] rd_idx;
    logic       rd_we;
    logic [2:0] csr_op;
    logic [11:0] csr_idx;
    word_t      alu_result;
    mem_op_e    mem_op;
    logic       mem_signed;
    mem_size_e  mem_size;
    logic [1:0] byte_offset;
    logic       misaligned;
  } m1_to_m2_s;

  typedef struct packed {
    word_t      addr;
    word_t      wdata;
    logic [3:0] wmask;
    mem_op_e    mem_op;
    mem_size_e  mem_size;
    logic [4:0] amo_alu_op;
  } dc_req_s;

  localparam int E_TO_M1_W  = $bits(e_to_m1_s);
  localparam int M1_TO_M2_W = $bits(m1_to_m2_s);
  localparam int DC_REQ_W   = $bits(dc_req_s);

endpackage

// File: rtl/letc_core_m1_store_align.sv
// rtl/letc_core_m1_store_align.sv - M1 address alignment, store lane steering and byte mask
//
// Purpose: combinational; from access size, address and store data produce
// the request address, lane-replicated write data, byte mask and misaligned flag.
// Config macro: LETC_M1_MISALIGN_TRAP_EN (defined: flag misaligned half/word
// accesses; undefined: never flag, force natural alignment instead).
// Ports:
//   mem_size  in  2   access size (mem_size_e encoding)
//   is_load   in  1   load access: byte mask forced to zero
//   addr_in   in  32  effective address from E
//   rs2       in  32  store / AMO source data
//   addr_out  out 32  address presented to the D-cache
//   wdata     out 32  store data replicated across lanes
//   wmask     out 4   byte enables
//   misaligned out 1  access not naturally aligned (trap build only)
module letc_core_m1_store_align
  import letc_core_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic        is_load,
  input  logic [31:0] addr_in,
  input  logic [31:0] rs2,
  output logic [31:0] addr_out,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic        misaligned
);

  always_comb begin
    addr_out   = addr_in;
    misaligned = 1'b0;
`ifdef LETC_M1_MISALIGN_TRAP_EN
    case (mem_size)
      MEM_SIZE_BYTE: misaligned = 1'b0;
      MEM_SIZE_HALF: misaligned = addr_in[0];
      default:       misaligned = |addr_in[1:0];
    endcase
`else
    case (mem_size)
      MEM_SIZE_BYTE: addr_out = addr_in;
      MEM_SIZE_HALF: addr_out[0] = 1'b0;
      default:       addr_out[1:0] = 2'b00;
    endcase
`endif
  end

  // Data is replicated into every lane so the cache only needs the mask.
  always_comb begin
    case (mem_size)
      MEM_SIZE_BYTE: begin
        wmask = 4'b0001 << addr_out[1:0];
        wdata = {4{rs2[7:0]}};
      end
      MEM_SIZE_HALF: begin
        wmask = 4'b0011 << {addr_out[1], 1'b0};
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        wmask = 4'hF;
        wdata = rs2;
      end
    endcase
    if (is_load) wmask = 4'h0;
  end

endmodule

// File: rtl/letc_core_stage_memory1.sv
// rtl/letc_core_stage_memory1.sv - LETC core M1 stage: D-cache request issue and branch redirect
//
// Purpose: registers the E->M1 payload, applies late rs2 forwarding, issues
// exactly one D-cache request per memory instruction (held until accepted),
// pulses the fetch redirect for taken branches and hands results to M2.
// Config macro: LETC_M1_MISALIGN_TRAP_EN (see letc_core_m1_store_align).
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   m1_fwd_rs2_idx/_idx_valid out  rs2 index presented to the forwarder
//   m1_fwd_rs2_use/_val       in   forwarded rs2 select and value
//   m1_ready                  out  0 while a D-cache request awaits acceptance
//   m1_flush, m1_stall        in   kill / hold the instruction in M1
//   e_to_m1_valid, e_to_m1    in   payload from E (e_to_m1_s)
//   m1_to_m2_valid, m1_to_m2  out  payload to M2 (m1_to_m2_s)
//   dc_req_valid/_ready, dc_req    D-cache request (dc_req_s)
//   m1_redirect_valid/_pc     out  one-cycle fetch redirect
module letc_core_stage_memory1
  import letc_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [4:0]            m1_fwd_rs2_idx,
  output logic                  m1_fwd_rs2_idx_valid,
  input  logic                  m1_fwd_rs2_use,
  input  logic [31:0]           m1_fwd_rs2_val,
  output logic                  m1_ready,
  input  logic                  m1_flush,
  input  logic                  m1_stall,
  input  logic                  e_to_m1_valid,
  input  logic [E_TO_M1_W-1:0]  e_to_m1,
  output logic                  m1_to_m2_valid,
  output logic [M1_TO_M2_W-1:0] m1_to_m2,
  output logic                  dc_req_valid,
  input  logic                  dc_req_ready,
  output logic [DC_REQ_W-1:0]   dc_req,
  output logic                  m1_redirect_valid,
  output logic [31:0]           m1_redirect_pc
);

  e_to_m1_s      ff_in_q, ff_in_d;
  logic          ff_in_valid_q, ff_in_valid_d;
  m1_req_state_e state_q, state_d;
  logic          redirect_done_q, redirect_done_d;

  logic [31:0] rs2;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        misaligned;
  logic        mem_req;
  logic        dc_accept;
  logic        mem_done;
  m1_to_m2_s   m2_s;
  dc_req_s     req_s;

  always_comb begin
    ff_in_d       = ff_in_q;
    ff_in_valid_d = ff_in_valid_q;
    if (!m1_stall) begin
      ff_in_d       = e_to_m1_s'(e_to_m1);
      ff_in_valid_d = e_to_m1_valid;
    end
  end

  assign m1_fwd_rs2_idx       = ff_in_q.rs2_idx;
  assign m1_fwd_rs2_idx_valid = ff_in_valid_q;
  assign rs2 = m1_fwd_rs2_use ? m1_fwd_rs2_val : ff_in_q.rs2_val;

  letc_core_m1_store_align u_store_align (
    .mem_size   (ff_in_q.mem_size),
    .is_load    (ff_in_q.mem_op == MEM_OP_LOAD),
    .addr_in    (ff_in_q.alu_result),
    .rs2        (rs2),
    .addr_out   (req_addr),
    .wdata      (req_wdata),
    .wmask      (req_wmask),
    .misaligned (misaligned)
  );

  assign mem_req      = ff_in_valid_q && (ff_in_q.mem_op != MEM_OP_NOP) && !misaligned;
  // SENT blocks reissue while a completed instruction sits stalled in M1.
  assign dc_req_valid = mem_req && !m1_flush && (state_q != M1_SENT);
  assign dc_accept    = dc_req_valid && dc_req_ready;
  assign m1_ready     = !((state_q == M1_REQ) ||
                          ((state_q == M1_IDLE) && dc_req_valid && !dc_req_ready));

  assign mem_done = (ff_in_q.mem_op == MEM_OP_NOP) || misaligned || dc_accept ||
                    (state_q == M1_SENT);
  assign m1_to_m2_valid = ff_in_valid_q && !m1_flush && !m1_stall && mem_done;

  // An instruction accepted in IDLE that also leaves this cycle needs no
  // SENT bookkeeping; going to SENT would wrongly mark its successor as done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      M1_IDLE: begin
        if (dc_accept)         state_d = m1_stall ? M1_SENT : M1_IDLE;
        else if (dc_req_valid) state_d = M1_REQ;
      end
      M1_REQ: begin
        if (m1_flush)       state_d = M1_IDLE;
        else if (dc_accept) state_d = M1_SENT;
      end
      M1_SENT: begin
        if (m1_flush || !m1_stall) state_d = M1_IDLE;
      end
      default: state_d = M1_IDLE;
    endcase
  end

  assign m1_redirect_valid = ff_in_valid_q && ff_in_q.branch_taken && !m1_flush &&
                             !m1_stall && !redirect_done_q;
  assign m1_redirect_pc    = ff_in_q.branch_target;

  always_comb begin
    redirect_done_d = redirect_done_q | m1_redirect_valid;
    if (!m1_stall) redirect_done_d = 1'b0;  // a new instruction is loaded
  end

  always_comb begin
    m2_s             = '0;
    m2_s.pc          = ff_in_q.pc;
    m2_s.rd_src      = ff_in_q.rd_src;
    m2_s.rd_idx      = ff_in_q.rd_idx;
    m2_s.rd_we       = ff_in_q.rd_we && !misaligned;
    m2_s.csr_op      = ff_in_q.csr_op;
    m2_s.csr_idx     = ff_in_q.csr_idx;
    m2_s.alu_result  = ff_in_q.alu_result;
    m2_s.mem_op      = ff_in_q.mem_op;
    m2_s.mem_signed  = ff_in_q.mem_signed;
    m2_s.mem_size    = ff_in_q.mem_size;
    m2_s.byte_offset = req_addr[1:0];
    m2_s.misaligned  = misaligned;
  end
  assign m1_to_m2 = m2_s;

  always_comb begin
    req_s            = '0;
    req_s.addr       = req_addr;
    req_s.wdata      = req_wdata;
    req_s.wmask      = req_wmask;
    req_s.mem_op     = ff_in_q.mem_op;
    req_s.mem_size   = ff_in_q.mem_size;
    req_s.amo_alu_op = ff_in_q.amo_alu_op;
  end
  assign dc_req = req_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_in_q         <= '0;
      ff_in_valid_q   <= 1'b0;
      state_q         <= M1_IDLE;
      redirect_done_q <= 1'b0;
    end else begin
      ff_in_q         <= ff_in_d;
      ff_in_valid_q   <= ff_in_valid_d;
      state_q         <= state_d;
      redirect_done_q <= redirect_done_d;
    end
  end

`ifndef SYNTHESIS
  a_no_flush_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(m1_flush && m1_stall));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (dc_req_valid && !dc_req_ready && !m1_flush) |=> (m1_flush || $stable(dc_req)));
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    m1_stall |=> $stable(m1_to_m2));
  a_valids_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({dc_req_valid, m1_to_m2_valid, m1_redirect_valid, m1_ready}));
`endif

endmodule

// File: tb/tb_letc_core_stage_memory1.sv
// tb/tb_letc_core_stage_memory1.sv - directed self-checking bench for letc_core_stage_memory1
module tb_letc_core_stage_memory1;
  import letc_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  fwd_idx;
  logic        fwd_idx_valid;
  logic        fwd_use;
  logic [31:0] fwd_val;
  logic        m1_ready;
  logic        m1_flush;
  logic        m1_stall;
  logic        ext_stall;
  logic        e_valid;
  e_to_m1_s    e_s;
  logic        m2_valid;
  m1_to_m2_s   m2;
  logic        dc_valid;
  logic        dc_ready;
  dc_req_s     dcr;
  logic        rd_valid;
  logic [31:0] rd_pc;

  int n_run = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int m2_cnt = 0;
  int rd_cnt = 0;
  int h0, m0, r0;

  always #5 clk = ~clk;

  // Hazard-unit model: hold M1 while a request is pending, never with a flush.
  assign m1_stall = (ext_stall || !m1_ready) && !m1_flush;

  letc_core_stage_memory1 dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .m1_fwd_rs2_idx       (fwd_idx),
    .m1_fwd_rs2_idx_valid (fwd_idx_valid),
    .m1_fwd_rs2_use       (fwd_use),
    .m1_fwd_rs2_val       (fwd_val),
    .m1_ready             (m1_ready),
    .m1_flush             (m1_flush),
    .m1_stall             (m1_stall),
    .e_to_m1_valid        (e_valid),
    .e_to_m1              (e_s),
    .m1_to_m2_valid       (m2_valid),
    .m1_to_m2             (m2),
    .dc_req_valid         (dc_valid),
    .dc_req_ready         (dc_ready),
    .dc_req               (dcr),
    .m1_redirect_valid    (rd_valid),
    .m1_redirect_pc       (rd_pc)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (dc_valid && dc_ready) hs_cnt++;
      if (m2_valid) m2_cnt++;
      if (rd_valid) rd_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic e_to_m1_s mk(input mem_op_e op, input mem_size_e sz,
                                  input logic [31:0] a, input logic [31:0] rs2v);
    e_to_m1_s e;
    e            = '0;
    e.pc         = 32'h0000_1000;
    e.rd_src     = RD_SRC_MEM;
    e.rd_idx     = 5'd7;
    e.rd_we      = (op == MEM_OP_LOAD);
    e.alu_result = a;
    e.rs2_idx    = 5'd9;
    e.rs2_val    = rs2v;
    e.mem_op     = op;
    e.mem_size   = sz;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle; on return it sits in M1.
  task automatic issue(input e_to_m1_s e);
    e_s     = e;
    e_valid = 1'b1;
    tick();
    e_valid = 1'b0;
    e_s     = mk(MEM_OP_NOP, MEM_SIZE_WORD, 32'h0, 32'h0);
  endtask

  task automatic snap;
    h0 = hs_cnt;
    m0 = m2_cnt;
    r0 = rd_cnt;
  endtask

  initial begin
    e_to_m1_s br;
    rst_n     = 1'b0;
    e_valid   = 1'b0;
    e_s       = mk(MEM_OP_NOP, MEM_SIZE_WORD, 32'h0, 32'h0);
    ext_stall = 1'b0;
    m1_flush  = 1'b0;
    dc_ready  = 1'b0;
    fwd_use   = 1'b0;
    fwd_val   = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_dc_valid", 32'(dc_valid), 0);
    check_eq("rst_m2_valid", 32'(m2_valid), 0);
    check_eq("rst_redirect", 32'(rd_valid), 0);
    check_eq("rst_m1_ready", 32'(m1_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: SW accepted immediately
    snap();
    issue(mk(MEM_OP_STORE, MEM_SIZE_WORD, 32'h100, 32'hDEADBEEF));
    dc_ready = 1'b1;
    #1;
    check_eq("t1_dc_valid", 32'(dc_valid), 1);
    check_eq("t1_addr", dcr.addr, 32'h100);
    check_eq("t1_wmask", 32'(dcr.wmask), 32'hF);
    check_eq("t1_wdata", dcr.wdata, 32'hDEADBEEF);
    check_eq("t1_m2_valid", 32'(m2_valid), 1);
    check_eq("t1_m1_ready", 32'(m1_ready), 1);
    check_eq("t1_fwd_idx", 32'(fwd_idx), 9);
    check_eq("t1_fwd_idx_valid", 32'(fwd_idx_valid), 1);
    tick();
    dc_ready = 1'b0;
    #1;
    check_eq("t1_dc_valid_after", 32'(dc_valid), 0);
    check_eq("t1_handshakes", 32'(hs_cnt - h0), 1);
    check_eq("t1_m2_count", 32'(m2_cnt - m0), 1);

    // 2: SB with cache back-pressure for three cycles
    snap();
    issue(mk(MEM_OP_STORE, MEM_SIZE_BYTE, 32'h103, 32'h000000AB));
    dc_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        tick();
        #1;
      end
      check_eq("t2_dc_valid_held", 32'(dc_valid), 1);
      check_eq("t2_wmask", 32'(dcr.wmask), 32'h8);
      check_eq("t2_wdata", dcr.wdata, 32'hABABABAB);
      check_eq("t2_m1_ready", 32'(m1_ready), 0);
      check_eq("t2_m2_valid_wait", 32'(m2_valid), 0);
    end
    tick();
    dc_ready = 1'b1;
    #1;
    check_eq("t2_dc_valid_accept", 32'(dc_valid), 1);
    check_eq("t2_m2_valid_accept", 32'(m2_valid), 0);
    tick();
    dc_ready = 1'b0;
    #1;
    check_eq("t2_dc_valid_sent", 32'(dc_valid), 0);
    check_eq("t2_m1_ready_sent", 32'(m1_ready), 1);
    check_eq("t2_m2_valid_sent", 32'(m2_valid), 1);
    tick();
    #1;
    check_eq("t2_handshakes", 32'(hs_cnt - h0), 1);
    check_eq("t2_m2_count", 32'(m2_cnt - m0), 1);

    // 3: LW accepted while the stage is held for two cycles
    snap();
    issue(mk(MEM_OP_LOAD, MEM_SIZE_WORD, 32'h200, 32'h12345678));
    dc_ready  = 1'b1;
    ext_stall = 1'b1;
    #1;
    check_eq("t3_dc_valid", 32'(dc_valid), 1);
    check_eq("t3_load_wmask", 32'(dcr.wmask), 0);
    check_eq("t3_m2_valid_stall", 32'(m2_valid), 0);
    tick();
    #1;
    check_eq("t3_no_reissue", 32'(dc_valid), 0);
    check_eq("t3_m2_valid_stall2", 32'(m2_valid), 0);
    tick();
    ext_stall = 1'b0;
    #1;
    check_eq("t3_m2_valid_release", 32'(m2_valid), 1);
    check_eq("t3_m2_alu_result", m2.alu_result, 32'h200);
    check_eq("t3_m2_rd_we", 32'(m2.rd_we), 1);
    tick();
    dc_ready = 1'b0;
    #1;
    check_eq("t3_handshakes", 32'(hs_cnt - h0), 1);
    check_eq("t3_m2_count", 32'(m2_cnt - m0), 1);

    // 4: SH pending then flushed; following SW uses forwarded rs2
    snap();
    issue(mk(MEM_OP_STORE, MEM_SIZE_HALF, 32'h106, 32'h1234CAFE));
    #1;
    check_eq("t4_dc_valid", 32'(dc_valid), 1);
    check_eq("t4_wmask", 32'(dcr.wmask), 32'hC);
    check_eq("t4_wdata", dcr.wdata, 32'hCAFECAFE);
    tick();
    m1_flush = 1'b1;
    e_s      = mk(MEM_OP_STORE, MEM_SIZE_WORD, 32'h108, 32'h55AA55AA);
    e_valid  = 1'b1;
    #1;
    check_eq("t4_flush_dc_valid", 32'(dc_valid), 0);
    check_eq("t4_flush_m2_valid", 32'(m2_valid), 0);
    tick();
    m1_flush = 1'b0;
    e_valid  = 1'b0;
    e_s      = mk(MEM_OP_NOP, MEM_SIZE_WORD, 32'h0, 32'h0);
    dc_ready = 1'b1;
    fwd_use  = 1'b1;
    fwd_val  = 32'h0BADF00D;
    #1;
    check_eq("t4_next_dc_valid", 32'(dc_valid), 1);
    check_eq("t4_next_addr", dcr.addr, 32'h108);
    check_eq("t4_next_fwd_wdata", dcr.wdata, 32'h0BADF00D);
    check_eq("t4_next_m2_valid", 32'(m2_valid), 1);
    tick();
    dc_ready = 1'b0;
    fwd_use  = 1'b0;
    #1;
    check_eq("t4_handshakes", 32'(hs_cnt - h0), 1);
    check_eq("t4_m2_count", 32'(m2_cnt - m0), 1);

    // 5: taken branch held one cycle -> single redirect pulse
    snap();
    br               = mk(MEM_OP_NOP, MEM_SIZE_WORD, 32'h0, 32'h0);
    br.branch_taken  = 1'b1;
    br.branch_target = 32'h2000;
    issue(br);
    ext_stall = 1'b1;
    #1;
    check_eq("t5_redirect_stalled", 32'(rd_valid), 0);
    tick();
    ext_stall = 1'b0;
    #1;
    check_eq("t5_redirect", 32'(rd_valid), 1);
    check_eq("t5_redirect_pc", rd_pc, 32'h2000);
    check_eq("t5_m2_valid", 32'(m2_valid), 1);
    tick();
    #1;
    check_eq("t5_redirect_after", 32'(rd_valid), 0);
    check_eq("t5_redirect_count", 32'(rd_cnt - r0), 1);

    // 6: misaligned LW
    issue(mk(MEM_OP_LOAD, MEM_SIZE_WORD, 32'h102, 32'h0));
    dc_ready = 1'b1;
    #1;
`ifdef LETC_M1_MISALIGN_TRAP_EN
    check_eq("t6_dc_valid", 32'(dc_valid), 0);
    check_eq("t6_misaligned", 32'(m2.misaligned), 1);
    check_eq("t6_rd_we", 32'(m2.rd_we), 0);
`else
    check_eq("t6_dc_valid", 32'(dc_valid), 1);
    check_eq("t6_addr", dcr.addr, 32'h100);
    check_eq("t6_misaligned", 32'(m2.misaligned), 0);
    check_eq("t6_rd_we", 32'(m2.rd_we), 1);
`endif
    check_eq("t6_m2_valid", 32'(m2_valid), 1);
    tick();

    // 6b: SB lane 1
    issue(mk(MEM_OP_STORE, MEM_SIZE_BYTE, 32'h101, 32'h0000005A));
    #1;
    check_eq("t6b_wmask", 32'(dcr.wmask), 32'h2);
    check_eq("t6b_wdata", dcr.wdata, 32'h5A5A5A5A);
    tick();
    dc_ready = 1'b0;

    // 7: reset while a request is pending
    issue(mk(MEM_OP_STORE, MEM_SIZE_WORD, 32'h300, 32'h11111111));
    #1;
    check_eq("t7_dc_valid", 32'(dc_valid), 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("t7_dc_valid_reset", 32'(dc_valid), 0);
    check_eq("t7_m1_ready_reset", 32'(m1_ready), 1);
    check_eq("t7_m2_valid_reset", 32'(m2_valid), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
